// File: rtl/alu_iterative_exec.sv
// Multi-cycle ALU execute stage: logic/arith ops complete in one cycle, shifts run bit-serially.
// Define ALU_BARREL_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter.
module alu_iterative_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             done_o
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_XOR   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_PASSB = 4'b1001;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                  r_state;
    logic [SHW-1:0]          r_cnt;
    logic signed [WIDTH-1:0] r_result;
    logic                    r_zero;
    logic                    r_done;
    logic                    r_ready;
    logic signed [WIDTH-1:0] r_work;
    logic [1:0]              r_sh_kind;

    logic                    w_accept;
    logic                    w_start_shift;
    logic signed [WIDTH-1:0] w_alu;
    logic signed [WIDTH-1:0] w_next_work;

    // Single-cycle result; in serial mode a shift only lands here when its amount is zero.
    function automatic logic [WIDTH-1:0] f_alu(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        res = '0;
        case (op)
            OP_ADD:   res = a + b;
            OP_SUB:   res = a - b;
            OP_XOR:   res = a ^ b;
            OP_OR:    res = a | b;
            OP_AND:   res = a & b;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL:   res = a << b[SHW-1:0];
            OP_SRL:   res = a >> b[SHW-1:0];
            OP_SRA:   res = $unsigned($signed(a) >>> b[SHW-1:0]);
`else
            OP_SLL:   res = a;
            OP_SRL:   res = a;
            OP_SRA:   res = a;
`endif
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_PASSB: res = b;
            default:  res = '0;
        endcase
        return res;
    endfunction

    // One shift step; kind is the low two op bits (01 SLL, 10 SRL, 11 SRA).
    function automatic logic [WIDTH-1:0] f_shift1(input logic [1:0] kind,
                                                  input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] res;
        case (kind)
            2'b01:   res = {w[WIDTH-2:0], 1'b0};
            2'b10:   res = {1'b0, w[WIDTH-1:1]};
            default: res = {w[WIDTH-1], w[WIDTH-1:1]};
        endcase
        return res;
    endfunction

    assign w_accept    = valid_i & r_ready;
    assign w_alu       = f_alu(ALU_Operation_i, a_i, b_i);
    assign w_next_work = f_shift1(r_sh_kind, r_work);

`ifdef ALU_BARREL_SHIFT_EN
    assign w_start_shift = 1'b0;
`else
    logic w_is_shift;
    assign w_is_shift    = (ALU_Operation_i == OP_SLL) || (ALU_Operation_i == OP_SRL) ||
                           (ALU_Operation_i == OP_SRA);
    assign w_start_shift = w_accept & w_is_shift & (b_i[SHW-1:0] != '0);
`endif

    // Control: state, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_shift) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= b_i[SHW-1:0];
                        r_ready <= 1'b0;
                    end else if (w_accept) begin
                        r_result <= w_alu;
                        r_zero   <= (w_alu == '0);
                        r_done   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_next_work;
                        r_zero   <= (w_next_work == '0);
                        r_done   <= 1'b1;
                        r_ready  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Datapath: working shift register, meaningful only while in SHIFT
    always_ff @(posedge clk) begin
        if (w_start_shift) begin
            r_work    <= a_i;
            r_sh_kind <= ALU_Operation_i[1:0];
        end else if (r_state == S_SHIFT) begin
            r_work <= w_next_work;
        end
    end

    assign ready_o  = r_ready;
    assign result_o = r_result;
    assign zero_o   = r_zero;
    assign done_o   = r_done;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed bench for alu_iterative_exec; expectations follow ALU_BARREL_SHIFT_EN when defined.
module tb_alu_iterative_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        done_o;

    int n_tests = 0;
    int n_fail  = 0;

    alu_iterative_exec #(.WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .ALU_Operation_i (ALU_Operation_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .result_o        (result_o),
        .zero_o          (zero_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input int n);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        return (n == 0) ? 1 : n + 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble inputs after acceptance, wait (bounded) for done and check it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        int low;
        logic [31:0] prev;
        prev            = result_o;
        valid_i         = 1'b1;
        ALU_Operation_i = op;
        a_i             = a;
        b_i             = b;
        step();
        valid_i         = 1'b0;
        ALU_Operation_i = 4'($urandom);
        a_i             = $urandom;
        b_i             = $urandom;
        lat = 1;
        low = 0;
        while (!done_o && lat < 80) begin
            if (!ready_o) low++;
            chk({tag, " hold"}, result_o, prev);
            step();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, result_o, exp_res);
        chk({tag, " zero"}, {31'd0, zero_o}, {31'd0, (exp_res == 32'd0)});
        chk({tag, " ready_low_cycles"}, 32'(low), 32'(exp_lat - 1));
        chk({tag, " ready_at_done"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        int dcount;
        reset           = 1'b0;
        valid_i         = 1'b0;
        ALU_Operation_i = 4'h0;
        a_i             = '0;
        b_i             = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        step();
        chk("reset result", result_o, 32'h0);
        chk("reset zero", {31'd0, zero_o}, 32'd1);
        chk("reset ready", {31'd0, ready_o}, 32'd1);
        chk("reset done", {31'd0, done_o}, 32'd0);

        run_op("ADD ovf", 4'b0000, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000);
        run_op("SUB eq", 4'b0001, 32'h5, 32'h5, 1, 32'h0);
        step();
        chk("done pulse width", {31'd0, done_o}, 32'd0);
        chk("result held idle", result_o, 32'h0);

        run_op("XOR", 4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_0FF0);
        run_op("OR", 4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_FFF0);
        run_op("AND", 4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_F000);
        run_op("PASSB", 4'b1001, 32'hDEAD_BEEF, 32'h1234_5678, 1, 32'h1234_5678);

        run_op("SRA 4", 4'b0111, 32'h8000_0000, 32'h4, lat_of(4), 32'hF800_0000);
        run_op("SLL 5", 4'b0101, 32'h1, 32'h25, lat_of(5), 32'h0000_0020);
        run_op("SRL 0", 4'b0110, 32'hF0, 32'h0, 1, 32'h0000_00F0);
        run_op("SRL 3", 4'b0110, 32'hF0, 32'h3, lat_of(3), 32'h0000_001E);
        run_op("SRA 31", 4'b0111, 32'h8000_0000, 32'd31, lat_of(31), 32'hFFFF_FFFF);

        run_op("SLT neg", 4'b1000, 32'hFFFF_FFFF, 32'h1, 1, 32'h1);
        run_op("SLT pos", 4'b1000, 32'h1, 32'hFFFF_FFFF, 1, 32'h0);
        run_op("SLT true2", 4'b1000, 32'h3, 32'h7, 1, 32'h1);
        run_op("OP 1111", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0);
        run_op("ADD pre", 4'b0000, 32'h10, 32'h20, 1, 32'h30);

        valid_i         = 1'b1;
        ALU_Operation_i = 4'b0101;
        a_i             = 32'h1;
        b_i             = 32'd20;
        step();
        valid_i = 1'b0;
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        chk("midreset result", result_o, 32'h0);
        chk("midreset zero", {31'd0, zero_o}, 32'd1);
        chk("midreset ready", {31'd0, ready_o}, 32'd1);
        chk("midreset done", {31'd0, done_o}, 32'd0);
        dcount = 0;
        repeat (25) begin
            step();
            if (done_o) dcount++;
        end
        chk("midreset no done", 32'(dcount), 32'd0);
        #2 reset = 1'b1;
        step();
        run_op("ADD after reset", 4'b0000, 32'h2, 32'h3, 1, 32'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_iterative_exec.md
Name: alu_iterative_exec

Overview:
- Multi-cycle execute stage directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code plus two operands and returns a registered result and a zero flag.
- Logic/arithmetic ops finish in 1 cycle. Shifts run bit-serially, one position per clock, to save area.
- Valid/ready handshake on the input side; one-cycle done pulse on the output side.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, $clog2(WIDTH) (5), shift-amount width; taken from b_i[SHW-1:0].

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_i  input  1  operation request.
- ready_o  output  1  block can accept a request this cycle.
- ALU_Operation_i  input  4  op code from ALU control.
- a_i  input  WIDTH  operand A (rs1).
- b_i  input  WIDTH  operand B (rs2 or immediate).
- result_o  output  WIDTH  registered result; holds until the next completion.
- zero_o  output  1  registered, (result_o == 0).
- done_o  output  1  one-cycle pulse: result_o/zero_o updated this cycle.

Behaviour:
- Reset (reset=0, async): state=IDLE, result_o=0, zero_o=1, done_o=0, ready_o=1. Reset mid-shift aborts the operation with no done_o.
- Op codes:
  - 0000 ADD, 0001 SUB, 0010 XOR, 0011 OR, 0100 AND.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLT (signed; result 1 or 0), 1001 PASSB (result=b_i).
  - 1010-1111: result 0, latency 1.
- Arithmetic: ADD/SUB are modulo 2^WIDTH, carry/overflow discarded. SRA replicates a_i[WIDTH-1].
- States: IDLE, SHIFT.
  - ready_o=1 in IDLE, 0 in SHIFT.
- Accept: valid_i & ready_o on a clock edge. Op, a_i and b_i are captured; later input changes are ignored.
- IDLE + accept, non-shift op: result computed and registered at that edge. done_o=1 next cycle; state stays IDLE. Latency 1; back-to-back accepts allowed every cycle.
- IDLE + accept, shift op with shamt=0: result=a_i, latency 1, no SHIFT entry.
- IDLE + accept, shift op with shamt=N>0: load the working register with a_i and the counter with N; go to SHIFT.
- SHIFT, each cycle: working register shifts by 1 in the op's direction/fill; counter decrements.
  - On the edge where the counter reaches 0: result_o and zero_o are loaded and state goes to IDLE.
  - done_o is high in the following cycle.
  - Total latency from accept to done_o: N+1 cycles.
- done_o and ready_o can both be 1 in the same cycle. A new accept in the done_o cycle is legal and does not disturb the current result_o (it updates at the next completion).
- valid_i while busy: ignored; no queuing. The requester must hold valid_i until ready_o.
- result_o/zero_o change only on completion or reset.

Optional Feature:
- Macro ALU_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter. All ops have latency 1, SHIFT state is never entered, and ready_o is constantly 1 outside reset.
- Undefined: bit-serial shift as described above, N+1 latency.

Test Plan:
- Reset, then no valid_i -> result_o=0, zero_o=1, ready_o=1, done_o=0.
- ADD a=0x7FFFFFFF, b=1 -> next cycle done_o=1, result_o=0x80000000, zero_o=0. Then SUB a=5, b=5 back-to-back -> done_o=1, result_o=0, zero_o=1.
- SRA a=0x80000000, b=4 -> ready_o=0 for 4 cycles, done_o 5 cycles after accept, result_o=0xF8000000. Operands changed during SHIFT have no effect.
- SLL a=1, b=0x25 (shamt 5) -> result_o=0x20 after 6 cycles. SRL a=0xF0, b=0 -> latency 1, result_o=0xF0.
- SLT a=0xFFFFFFFF, b=1 -> result_o=1. Op 1111 -> result_o=0, zero_o=1.
- Assert reset low during SHIFT of SLL shamt=20 -> immediate reset values, no done_o. After release, a new ADD 2+3 -> result_o=5.
- ALU_BARREL_SHIFT_EN defined: SRA a=0x80000000, b=31 -> done_o next cycle, result_o=0xFFFFFFFF, ready_o never low.
